// File: rtl/mux2_arb_pkg.sv
// Shared types and sizing helpers for the two-requester packet arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam int unsigned MAX_BEATS_DEF = 16;
  localparam int unsigned CNT_W         = $clog2(MAX_BEATS_DEF + 1);

  // Beat counter width for an arbitrary per-grant beat limit.
  function automatic int unsigned cnt_width(input int unsigned max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/mux2_data_sel.sv
// Combinational 2:1 payload mux; y follows b when sel is high.
module mux2_data_sel #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered valid/ready stream
// between two requesters, with a beat cap that forces a packet break.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              trunc
);

  localparam int unsigned              BEAT_CNT_W = cnt_width(MAX_BEATS);
  localparam logic [BEAT_CNT_W-1:0]    CNT_END    = BEAT_CNT_W'(MAX_BEATS - 1);

  state_t                  state_q, state_d;
  logic                    prio_q, prio_d;
  logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    sel_q, sel_d;
  logic                    trunc_q, trunc_d;

  logic                    load_en;
  logic                    accept;
  logic                    cur_last;
  logic                    at_cap;
  logic                    end_beat;
  logic [DATA_W-1:0]       mux_data;

  mux2_data_sel #(.DATA_W(DATA_W)) u_data_sel (
    .sel (sel_q),
    .a   (req0_data),
    .b   (req1_data),
    .y   (mux_data)
  );

  assign load_en    = !out_valid_q || out_ready;
  assign req0_ready = (state_q == GRANT0) && load_en;
  assign req1_ready = (state_q == GRANT1) && load_en;
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign cur_last   = sel_q ? req1_last : req0_last;
  assign at_cap     = (cnt_q == CNT_END);
  assign end_beat   = cur_last || at_cap;

  // Next-state: arbitration, beat counting and output register load.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sel_d       = sel_q;
    trunc_d     = trunc_q;

    case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) state_d = prio_q ? GRANT1 : GRANT0;
        else if (req0_valid)          state_d = GRANT0;
        else if (req1_valid)          state_d = GRANT1;
      end
      GRANT0: begin
        if (accept && end_beat) begin
          prio_d  = 1'b1;
          state_d = req1_valid ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (accept && end_beat) begin
          prio_d  = 1'b0;
          state_d = req0_valid ? GRANT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = end_beat;
      cnt_d       = end_beat ? '0 : cnt_q + BEAT_CNT_W'(1);
      if (at_cap && !cur_last) trunc_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Select tracks the granted requester and holds through IDLE.
    if (state_d == GRANT1)      sel_d = 1'b1;
    else if (state_d == GRANT0) sel_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sel_q       <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      sel_q       <= sel_d;
      trunc_q     <= trunc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sel       = sel_q;
  assign trunc     = trunc_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: packet-level round-robin reference model with
// directed scenarios and randomized packet mixes under random backpressure.
module tb_mux2_rr_arbiter;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MAX_BEATS = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    int                src;
    bit                forced;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req0_last, req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid, req1_last, req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic              out_valid, out_last, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              sel, trunc;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .sel        (sel),
    .trunc      (trunc)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t q0[$];
  beat_t q1[$];
  exp_t  expq[$];
  int    model_prio = 0;
  bit    trunc_exp  = 1'b0;
  int    ready_mode = 0;
  int    first_out;
  int    last_fire;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic add_pkt(input int src, input int len, input int seed);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = (seed == 0) ? DATA_W'($urandom) : DATA_W'(seed * (i + 1));
      b.last = (i == len - 1);
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  // Expected output stream: alternate between requesters at every packet (or
  // beat-cap) boundary whenever the other one still has beats pending.
  task automatic build_expected();
    int    pos[2];
    int    sz[2];
    int    cur;
    int    n;
    beat_t b;
    exp_t  e;
    pos[0] = 0; pos[1] = 0;
    sz[0]  = q0.size(); sz[1] = q1.size();
    while (pos[0] < sz[0] || pos[1] < sz[1]) begin
      cur = (pos[model_prio] < sz[model_prio]) ? model_prio : 1 - model_prio;
      n = 0;
      do begin
        b = (cur == 0) ? q0[pos[0]] : q1[pos[1]];
        pos[cur]++;
        n++;
        e.data   = b.data;
        e.forced = !b.last && (n == int'(MAX_BEATS));
        e.last   = b.last || e.forced;
        e.src    = cur;
        expq.push_back(e);
      end while (!e.last);
      model_prio = 1 - cur;
    end
  endtask

  task automatic drive(input int c);
    req0_valid = (q0.size() > 0);
    req0_data  = (q0.size() > 0) ? q0[0].data : '0;
    req0_last  = (q0.size() > 0) ? q0[0].last : 1'b0;
    req1_valid = (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0].data : '0;
    req1_last  = (q1.size() > 0) ? q1[0].last : 1'b0;
    case (ready_mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = !(c >= 4 && c <= 6);
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    q0.delete(); q1.delete(); expq.delete();
    model_prio = 0;
    trunc_exp  = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    out_ready  = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_trunc", 32'(trunc), 0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_phase(input int budget);
    bit   a0, a1;
    exp_t h;
    build_expected();
    first_out = -1;
    last_fire = -1;
    for (int c = 0; c < budget && expq.size() > 0; c++) begin
      drive(c);
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (req0_ready) check("sel_grant0", 32'(sel), 0);
      if (req1_ready) check("sel_grant1", 32'(sel), 1);
      if (out_valid && !out_ready) check("ready_backpressure", 32'({req1_ready, req0_ready}), 0);
      if (out_valid) begin
        if (first_out < 0) first_out = c;
        h = expq[0];
        trunc_exp = trunc_exp | h.forced;
        check("out_data", 32'(out_data), 32'(h.data));
        check("out_last", 32'(out_last), 32'(h.last));
        check("trunc", 32'(trunc), 32'(trunc_exp));
        if (out_ready) begin
          void'(expq.pop_front());
          last_fire = c;
        end
      end
      @(posedge clk); #1;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
    end
    check("phase_drained", 32'(expq.size()), 0);
    // Nothing further may appear once the expected stream is exhausted.
    ready_mode = 0;
    for (int c = 0; c < 2; c++) begin
      drive(0);
      @(negedge clk);
      check("no_extra_beat", 32'(out_valid), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit a1;

    do_reset(2);

    // Single requester: latency and back-to-back beats.
    ready_mode = 0;
    add_pkt(0, 3, 'h11);
    run_phase(50);
    check("first_beat_latency", 32'(first_out), 2);
    check("single_last_fire", 32'(last_fire), 4);

    // Contention from reset: gapless alternation, priority flips.
    do_reset(2);
    ready_mode = 0;
    add_pkt(0, 2, 'h21); add_pkt(0, 2, 'h31);
    add_pkt(1, 2, 'h41); add_pkt(1, 2, 'h51);
    run_phase(60);
    check("contend_latency", 32'(first_out), 2);
    check("contend_gapless", 32'(last_fire), 9);

    // Backpressure mid-packet.
    ready_mode = 2;
    add_pkt(0, 6, 'h07);
    run_phase(60);

    // Beat cap truncation with the other requester waiting.
    ready_mode = 1;
    add_pkt(0, 2, 'h61); add_pkt(0, 3, 'h71);
    add_pkt(1, 6, 'h09);
    run_phase(200);
    check("trunc_sticky", 32'(trunc), 1);

    // Reset in the middle of a 4-beat packet.
    ready_mode = 0;
    add_pkt(1, 4, 'h13);
    acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      drive(c);
      @(negedge clk);
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a1) begin
        void'(q1.pop_front());
        acc++;
      end
    end
    check("midpkt_accepts", 32'(acc), 2);
    check("midpkt_sel_before", 32'(sel), 1);
    do_reset(1);
    ready_mode = 0;
    add_pkt(1, 4, 'h15);
    run_phase(60);
    check("post_reset_latency", 32'(first_out), 2);
    check("post_reset_no_trunc", 32'(trunc), 0);

    // Randomized packet mixes under random backpressure.
    for (int r = 0; r < 10; r++) begin
      int np0, np1;
      ready_mode = 1;
      np0 = $urandom_range(0, 3);
      np1 = $urandom_range(0, 3);
      if (np0 + np1 == 0) np0 = 1;
      for (int k = 0; k < np0; k++) add_pkt(0, $urandom_range(1, 7), 0);
      for (int k = 0; k < np1; k++) add_pkt(1, $urandom_range(1, 7), 0);
      run_phase(600);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
